// File: rtl/perceptron_predictor_pipe.sv
// Clocked perceptron branch predictor: 1-cycle predict path, speculative/architectural GHRs,
// 3-state training FSM. Define PERCEPTRON_STATS_EN to add prediction/mispredict counters.
module perceptron_predictor_pipe #(
    parameter int          PC_W     = 32,
    parameter int          HIST_LEN = 8,
    parameter int          WEIGHT_W = 8,
    parameter int          IDX_W    = 8,
    parameter logic [15:0] THETA    = 16'd29
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_predValid_1,
    input  logic [PC_W-1:0]       i_predPc_32,
    output logic                  o_predValid_1,
    output logic                  o_predTaken_1,
    output logic [WEIGHT_W+3:0]   o_predSum,
    input  logic                  i_updValid_1,
    output logic                  o_updReady_1,
    input  logic [PC_W-1:0]       i_updPc_32,
    input  logic                  i_updTaken_1,
    input  logic                  i_updMispred_1,
    output logic [HIST_LEN-1:0]   o_specGhr
`ifdef PERCEPTRON_STATS_EN
    ,
    output logic [31:0]           o_predCount_32,
    output logic [31:0]           o_mispredCount_32
`endif
);

    localparam int DEPTH = 2 ** IDX_W;
    localparam int SUM_W = WEIGHT_W + 4;
    localparam int NW    = HIST_LEN + 1;
    localparam logic [WEIGHT_W-1:0] W_MAX = {1'b0, {(WEIGHT_W-1){1'b1}}};
    localparam logic [WEIGHT_W-1:0] W_MIN = {1'b1, {(WEIGHT_W-1){1'b0}}};

    // Element 0 of a row is the bias, element i+1 is the weight for GHR bit i.
    typedef logic [NW-1:0][WEIGHT_W-1:0] row_t;
    typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_WRITE} upd_state_e;

    function automatic logic [SUM_W-1:0] sext_w(input logic [WEIGHT_W-1:0] w);
        return {{(SUM_W-WEIGHT_W){w[WEIGHT_W-1]}}, w};
    endfunction

    function automatic logic [SUM_W-1:0] row_sum(input row_t row, input logic [HIST_LEN-1:0] hist);
        logic [SUM_W-1:0] acc;
        acc = sext_w(row[0]);
        for (int i = 0; i < HIST_LEN; i++) begin
            if (hist[i]) acc = acc + sext_w(row[i+1]);
            else         acc = acc - sext_w(row[i+1]);
        end
        return acc;
    endfunction

    function automatic logic [WEIGHT_W-1:0] sat_step(input logic [WEIGHT_W-1:0] w, input logic inc);
        if (inc) return (w == W_MAX) ? w : w + WEIGHT_W'(1);
        else     return (w == W_MIN) ? w : w - WEIGHT_W'(1);
    endfunction

    row_t                 wt_q [DEPTH];
    upd_state_e           state_q, state_d;
    logic [HIST_LEN-1:0]  spec_ghr_q, spec_ghr_d;
    logic [HIST_LEN-1:0]  arch_ghr_q, arch_ghr_d;
    logic [HIST_LEN-1:0]  train_hist_q, train_hist_d;
    logic [IDX_W-1:0]     upd_row_q, upd_row_d;
    logic                 upd_taken_q, upd_taken_d;
    logic                 upd_mispred_q, upd_mispred_d;
    logic                 pred_valid_q, pred_valid_d;
    logic                 pred_taken_q, pred_taken_d;
    logic [SUM_W-1:0]     pred_sum_q, pred_sum_d;

    logic [IDX_W-1:0]     pred_row;
    logic [SUM_W-1:0]     pred_sum_c;
    logic                 pred_taken_c;
    logic [SUM_W-1:0]     upd_sum_c;
    logic [SUM_W-1:0]     upd_abs_c;
    logic                 train_c;
    logic                 upd_accept;
    logic                 wr_en;
    row_t                 new_row_c;

    assign pred_row     = i_predPc_32[IDX_W+1:2];
    assign pred_sum_c   = row_sum(wt_q[pred_row], spec_ghr_q);
    assign pred_taken_c = ~pred_sum_c[SUM_W-1];

    always_comb begin
        pred_valid_d = i_predValid_1;
        pred_sum_d   = pred_sum_q;
        pred_taken_d = pred_taken_q;
        if (i_predValid_1) begin
            pred_sum_d   = pred_sum_c;
            pred_taken_d = pred_taken_c;
        end
    end

    // Training decision and the saturated row image for the WRITE state.
    always_comb begin
        upd_sum_c = row_sum(wt_q[upd_row_q], train_hist_q);
        upd_abs_c = upd_sum_c[SUM_W-1] ? (~upd_sum_c + SUM_W'(1)) : upd_sum_c;
        train_c   = upd_mispred_q || (32'(upd_abs_c) <= 32'(THETA));
        new_row_c = wt_q[upd_row_q];
        new_row_c[0] = sat_step(wt_q[upd_row_q][0], upd_taken_q);
        for (int i = 0; i < HIST_LEN; i++) begin
            new_row_c[i+1] = sat_step(wt_q[upd_row_q][i+1], upd_taken_q == train_hist_q[i]);
        end
    end

    always_comb begin
        state_d       = state_q;
        arch_ghr_d    = arch_ghr_q;
        train_hist_d  = train_hist_q;
        upd_row_d     = upd_row_q;
        upd_taken_d   = upd_taken_q;
        upd_mispred_d = upd_mispred_q;
        upd_accept    = 1'b0;
        wr_en         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_updValid_1) begin
                    upd_accept    = 1'b1;
                    upd_row_d     = i_updPc_32[IDX_W+1:2];
                    upd_taken_d   = i_updTaken_1;
                    upd_mispred_d = i_updMispred_1;
                    train_hist_d  = arch_ghr_q;
                    arch_ghr_d    = {arch_ghr_q[HIST_LEN-2:0], i_updTaken_1};
                    state_d       = ST_CALC;
                end
            end
            ST_CALC:  state_d = train_c ? ST_WRITE : ST_IDLE;
            ST_WRITE: begin
                wr_en   = 1'b1;
                state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Mispredict recovery overrides any same-edge speculative shift.
    always_comb begin
        spec_ghr_d = spec_ghr_q;
        if (upd_accept && i_updMispred_1) spec_ghr_d = arch_ghr_d;
        else if (i_predValid_1)           spec_ghr_d = {spec_ghr_q[HIST_LEN-2:0], pred_taken_c};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= ST_IDLE;
            spec_ghr_q    <= '0;
            arch_ghr_q    <= '0;
            train_hist_q  <= '0;
            upd_row_q     <= '0;
            upd_taken_q   <= 1'b0;
            upd_mispred_q <= 1'b0;
            pred_valid_q  <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_sum_q    <= '0;
            for (int r = 0; r < DEPTH; r++) wt_q[r] <= '0;
        end else begin
            state_q       <= state_d;
            spec_ghr_q    <= spec_ghr_d;
            arch_ghr_q    <= arch_ghr_d;
            train_hist_q  <= train_hist_d;
            upd_row_q     <= upd_row_d;
            upd_taken_q   <= upd_taken_d;
            upd_mispred_q <= upd_mispred_d;
            pred_valid_q  <= pred_valid_d;
            pred_taken_q  <= pred_taken_d;
            pred_sum_q    <= pred_sum_d;
            if (wr_en) wt_q[upd_row_q] <= new_row_c;
        end
    end

    assign o_predValid_1 = pred_valid_q;
    assign o_predTaken_1 = pred_taken_q;
    assign o_predSum     = pred_sum_q;
    assign o_updReady_1  = (state_q == ST_IDLE);
    assign o_specGhr     = spec_ghr_q;

`ifdef PERCEPTRON_STATS_EN
    logic [31:0] pred_cnt_q, pred_cnt_d;
    logic [31:0] mis_cnt_q, mis_cnt_d;

    always_comb begin
        pred_cnt_d = pred_cnt_q;
        mis_cnt_d  = mis_cnt_q;
        if (i_predValid_1 && pred_cnt_q != 32'hFFFF_FFFF) pred_cnt_d = pred_cnt_q + 32'd1;
        if (upd_accept && i_updMispred_1 && mis_cnt_q != 32'hFFFF_FFFF) mis_cnt_d = mis_cnt_q + 32'd1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pred_cnt_q <= '0;
            mis_cnt_q  <= '0;
        end else begin
            pred_cnt_q <= pred_cnt_d;
            mis_cnt_q  <= mis_cnt_d;
        end
    end

    assign o_predCount_32    = pred_cnt_q;
    assign o_mispredCount_32 = mis_cnt_q;
`endif

    logic unused_pc_bits;
    assign unused_pc_bits = ^{i_predPc_32[PC_W-1:IDX_W+2], i_predPc_32[1:0],
                              i_updPc_32[PC_W-1:IDX_W+2], i_updPc_32[1:0]};

endmodule

// File: tb/tb_perceptron_predictor_pipe.sv
// Directed bench for perceptron_predictor_pipe: default instance plus a WEIGHT_W=4 / THETA=255
// instance for saturation.
module tb_perceptron_predictor_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // instance A: default parameters
  logic        a_pred_valid = 0, a_out_valid, a_out_taken;
  logic [31:0] a_pred_pc = '0;
  logic [11:0] a_out_sum;
  logic        a_upd_valid = 0, a_upd_ready, a_upd_taken = 0, a_upd_mispred = 0;
  logic [31:0] a_upd_pc = '0;
  logic [7:0]  a_ghr;
  // instance B: WEIGHT_W=4, THETA=255
  logic        b_pred_valid = 0, b_out_valid, b_out_taken;
  logic [31:0] b_pred_pc = '0;
  logic [7:0]  b_out_sum;
  logic        b_upd_valid = 0, b_upd_ready, b_upd_taken = 0, b_upd_mispred = 0;
  logic [31:0] b_upd_pc = '0;
  logic [7:0]  b_ghr;
`ifdef PERCEPTRON_STATS_EN
  logic [31:0] a_pcnt, a_mcnt, b_pcnt, b_mcnt;
`endif

  perceptron_predictor_pipe u_a (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_predValid_1(a_pred_valid), .i_predPc_32(a_pred_pc),
    .o_predValid_1(a_out_valid), .o_predTaken_1(a_out_taken), .o_predSum(a_out_sum),
    .i_updValid_1(a_upd_valid), .o_updReady_1(a_upd_ready), .i_updPc_32(a_upd_pc),
    .i_updTaken_1(a_upd_taken), .i_updMispred_1(a_upd_mispred), .o_specGhr(a_ghr)
`ifdef PERCEPTRON_STATS_EN
    , .o_predCount_32(a_pcnt), .o_mispredCount_32(a_mcnt)
`endif
  );

  perceptron_predictor_pipe #(.WEIGHT_W(4), .THETA(16'd255)) u_b (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_predValid_1(b_pred_valid), .i_predPc_32(b_pred_pc),
    .o_predValid_1(b_out_valid), .o_predTaken_1(b_out_taken), .o_predSum(b_out_sum),
    .i_updValid_1(b_upd_valid), .o_updReady_1(b_upd_ready), .i_updPc_32(b_upd_pc),
    .i_updTaken_1(b_upd_taken), .i_updMispred_1(b_upd_mispred), .o_specGhr(b_ghr)
`ifdef PERCEPTRON_STATS_EN
    , .o_predCount_32(b_pcnt), .o_mispredCount_32(b_mcnt)
`endif
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic a_predict(input logic [31:0] pc);
    a_pred_valid = 1'b1;
    a_pred_pc    = pc;
    @(posedge clk); #1;
    a_pred_valid = 1'b0;
  endtask

  task automatic a_update(input logic [31:0] pc, input logic tk, input logic mp);
    a_upd_valid   = 1'b1;
    a_upd_pc      = pc;
    a_upd_taken   = tk;
    a_upd_mispred = mp;
    @(posedge clk); #1;
    a_upd_valid = 1'b0;
  endtask

  task automatic a_wait_idle(input string name);
    int n = 0;
    while (a_upd_ready !== 1'b1 && n < 16) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, int'(a_upd_ready), 1);
  endtask

  task automatic b_update(input logic [31:0] pc, input logic tk, input logic mp);
    b_upd_valid   = 1'b1;
    b_upd_pc      = pc;
    b_upd_taken   = tk;
    b_upd_mispred = mp;
    @(posedge clk); #1;
    b_upd_valid = 1'b0;
  endtask

  task automatic b_wait_idle(input string name);
    int n = 0;
    while (b_upd_ready !== 1'b1 && n < 16) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, int'(b_upd_ready), 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    logic [31:0] pc;
    int          exp_sum;
    logic        exp_taken;
    logic [7:0]  exp_ghr;
  } pvec_t;

  pvec_t tbl[11];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // row 0x40 holds bias -1, w_i +1 when the table runs, so sum = 2*popcount(ghr) - 9
    tbl[0]  = '{32'h100, -9, 1'b0, 8'h00};
    tbl[1]  = '{32'h104,  0, 1'b1, 8'h01};
    tbl[2]  = '{32'h100, -7, 1'b0, 8'h02};
    tbl[3]  = '{32'h000,  0, 1'b1, 8'h05};
    tbl[4]  = '{32'h100, -5, 1'b0, 8'h0A};
    tbl[5]  = '{32'h500, -5, 1'b0, 8'h14};
    tbl[6]  = '{32'h3FC,  0, 1'b1, 8'h29};
    tbl[7]  = '{32'h100, -3, 1'b0, 8'h52};
    tbl[8]  = '{32'h102, -3, 1'b0, 8'hA4};
    tbl[9]  = '{32'h104,  0, 1'b1, 8'h49};
    tbl[10] = '{32'h100, -3, 1'b0, 8'h92};

    // reset state
    do_reset();
    check("rst_pred_valid", int'(a_out_valid), 0);
    check("rst_pred_taken", int'(a_out_taken), 0);
    check("rst_pred_sum", int'($signed(a_out_sum)), 0);
    check("rst_upd_ready", int'(a_upd_ready), 1);
    check("rst_spec_ghr", int'(a_ghr), 0);

    // first prediction on zero weights
    a_predict(32'h100);
    check("p0_valid", int'(a_out_valid), 1);
    check("p0_sum", int'($signed(a_out_sum)), 0);
    check("p0_taken", int'(a_out_taken), 1);
    check("p0_ghr", int'(a_ghr), 8'h01);
    @(posedge clk); #1;
    check("p0_valid_pulse", int'(a_out_valid), 0);

    // mispredicted not-taken update trains row 0x40 and restores spec GHR
    a_update(32'h100, 1'b0, 1'b1);
    check("mp_ready_c1", int'(a_upd_ready), 0);
    check("mp_spec_ghr", int'(a_ghr), 8'h00);
    @(posedge clk); #1;
    check("mp_ready_c2", int'(a_upd_ready), 0);
    @(posedge clk); #1;
    check("mp_ready_c3", int'(a_upd_ready), 1);
`ifdef PERCEPTRON_STATS_EN
    check("stat_pred_cnt", int'(a_pcnt), 1);
    check("stat_mis_cnt", int'(a_mcnt), 1);
`endif

    // back-to-back prediction table
    a_pred_valid = 1'b1;
    for (int i = 0; i < 11; i++) begin
      a_pred_pc = tbl[i].pc;
      @(posedge clk); #1;
      check($sformatf("tbl%0d_valid", i), int'(a_out_valid), 1);
      check($sformatf("tbl%0d_sum", i), int'($signed(a_out_sum)), tbl[i].exp_sum);
      check($sformatf("tbl%0d_taken", i), int'(a_out_taken), int'(tbl[i].exp_taken));
      check($sformatf("tbl%0d_ghr", i), int'(a_ghr), int'(tbl[i].exp_ghr));
    end
    a_pred_valid = 1'b0;

    // prediction and mispredict update on the same edge (spec GHR 0x92 beforehand)
    a_pred_valid  = 1'b1;
    a_pred_pc     = 32'h100;
    a_update(32'h200, 1'b1, 1'b1);
    a_pred_valid  = 1'b0;
    check("same_valid", int'(a_out_valid), 1);
    check("same_sum", int'($signed(a_out_sum)), -3);
    check("same_taken", int'(a_out_taken), 0);
    check("same_ghr", int'(a_ghr), 8'h01);
    a_wait_idle("same_idle");
    // row 0x80: bias +1, w_i -1; spec GHR 0x01 gives 1 - 1 + 7
    a_predict(32'h200);
    check("r80_sum", int'($signed(a_out_sum)), 7);
    check("r80_taken", int'(a_out_taken), 1);

    // confident correct update: |sum| = 40 > THETA, no training
    do_reset();
    for (int k = 0; k < 8; k++) begin
      a_update(32'h300, 1'b0, 1'b1);
      a_wait_idle("ctr_train_idle");
    end
    for (int k = 0; k < 2; k++) begin
      a_update(32'h400, 1'b1, 1'b0);
      a_wait_idle("ctr_ghr_idle");
    end
    a_update(32'h300, 1'b0, 1'b0);
    check("ctr_ready_c1", int'(a_upd_ready), 0);
    @(posedge clk); #1;
    check("ctr_ready_c2", int'(a_upd_ready), 1);
    // row 0xC0 is bias -8, w_i +8; spec GHR 0 gives -72
    a_predict(32'h300);
    check("ctr_row_sum", int'($signed(a_out_sum)), -72);
    check("ctr_row_taken", int'(a_out_taken), 0);

    // reset during CALC aborts training
    do_reset();
    a_update(32'h100, 1'b0, 1'b1);
    a_wait_idle("rc_first_idle");
    a_update(32'h100, 1'b0, 1'b1);
    check("rc_busy", int'(a_upd_ready), 0);
    #2 rst_n = 1'b0;
    #1;
    check("rc_ready_async", int'(a_upd_ready), 1);
    check("rc_ghr_async", int'(a_ghr), 0);
`ifdef PERCEPTRON_STATS_EN
    check("rc_pred_cnt", int'(a_pcnt), 0);
    check("rc_mis_cnt", int'(a_mcnt), 0);
`endif
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    a_predict(32'h100);
    check("rc_sum", int'($signed(a_out_sum)), 0);
    check("rc_taken", int'(a_out_taken), 1);

    // saturation on the narrow instance: bias -> -8, w_i -> +7
    for (int k = 0; k < 10; k++) begin
      b_update(32'h100, 1'b0, 1'b0);
      b_wait_idle("sat_idle");
    end
    b_pred_valid = 1'b1;
    b_pred_pc    = 32'h100;
    @(posedge clk); #1;
    b_pred_valid = 1'b0;
    check("sat_valid", int'(b_out_valid), 1);
    check("sat_sum", int'($signed(b_out_sum)), -64);
    check("sat_taken", int'(b_out_taken), 0);
    check("sat_ghr", int'(b_ghr), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
